// File: rtl/craps_datapath_n.sv
// craps_datapath_n
//   Dice datapath for the craps game. NUM_DICE free-running LFSR dice are
//   each mapped to a face 1..SIDES. A roll request captures every die and a
//   sequential accumulator sums them one die per cycle. The completed sum is
//   classified (seven-out / natural / craps) and compared with a held point.
//
// Ports
//   clock, reset      posedge clock, synchronous active-high reset
//   roll              roll request pulse; dropped (roll_dropped) while busy
//   set_point         point <= sum, only while idle; also restarts roll_count
//   clear_point       invalidates the point in any state; wins over set_point
//   dice              captured die values, die i at [4i+3:4i]
//   sum               sum of the last completed roll
//   done              one-cycle pulse when dice/sum/flags/eq are fresh
//   busy              roll in progress (acceptance until done)
//   roll_dropped      one-cycle pulse: a roll arrived while busy
//   point/point_valid held point and its valid flag
//   seven_out, natural, craps, eq   classification of sum, held until next done
//   roll_count        completed rolls since reset/set_point, saturating
module craps_datapath_n #(
    parameter int NUM_DICE   = 2,
    parameter int SIDES      = 6,
    parameter int LFSR_W     = 8,
    parameter int SEED0      = 1,
    parameter int SEED_STEP  = 36,
    parameter int SUM_W      = 8,
    parameter int ROLL_CNT_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    roll,
    input  logic                    set_point,
    input  logic                    clear_point,
    output logic [NUM_DICE*4-1:0]   dice,
    output logic [SUM_W-1:0]        sum,
    output logic                    done,
    output logic                    busy,
    output logic                    roll_dropped,
    output logic [SUM_W-1:0]        point,
    output logic                    point_valid,
    output logic                    seven_out,
    output logic                    natural,
    output logic                    craps,
    output logic                    eq,
    output logic [ROLL_CNT_W-1:0]   roll_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EVAL  = 2'd2
    } state_t;

    localparam int IDX_W = 4;

    // Maximal-length feedback taps (bit t-1 set for tap t) for each width.
    function automatic logic [15:0] tap_mask(input int unsigned w);
        case (w)
            32'd4:   return 16'h000C;
            32'd5:   return 16'h0014;
            32'd6:   return 16'h0030;
            32'd7:   return 16'h0060;
            32'd8:   return 16'h00B8;
            32'd9:   return 16'h0110;
            32'd10:  return 16'h0240;
            32'd11:  return 16'h0500;
            32'd12:  return 16'h0829;
            32'd13:  return 16'h100D;
            32'd14:  return 16'h2015;
            32'd15:  return 16'h6000;
            32'd16:  return 16'hD008;
            default: return 16'h00B8;
        endcase
    endfunction

    localparam logic [15:0]      TAPS     = tap_mask(LFSR_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DICE - 1);

    // Seed of die i; the all-zero state would lock the LFSR, so it maps to 1.
    function automatic logic [LFSR_W-1:0] seed_of(input int unsigned i);
        logic [LFSR_W-1:0] s;
        s = LFSR_W'(SEED0 + int'(i) * SEED_STEP);
        if (s == {LFSR_W{1'b0}}) begin
            return {{(LFSR_W-1){1'b0}}, 1'b1};
        end else begin
            return s;
        end
    endfunction

    // Fibonacci shift-left step: new LSB is the parity of the tapped bits.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & TAPS[LFSR_W-1:0])};
    endfunction

    logic [LFSR_W-1:0]     lfsr_r [NUM_DICE];
    logic [NUM_DICE*4-1:0] die_s;
    logic [3:0]            cur_die_s;
    state_t                state_r;
    logic [SUM_W-1:0]      acc_r;
    logic [IDX_W-1:0]      idx_r;

    // Free-running dice LFSRs; they step every clock so the outcome depends on roll timing.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_DICE; i++) begin
            if (reset) begin
                lfsr_r[i] <= seed_of(i);
            end else begin
                lfsr_r[i] <= lfsr_next(lfsr_r[i]);
            end
        end
    end

    // Map each LFSR state onto a face value 1..SIDES.
    always_comb begin
        die_s = {(NUM_DICE*4){1'b0}};
        for (int i = 0; i < NUM_DICE; i++) begin
            die_s[4*i +: 4] = 4'(lfsr_r[i] % LFSR_W'(SIDES)) + 4'd1;
        end
    end

    // Captured die currently addressed by the accumulator index.
    always_comb begin
        cur_die_s = 4'd0;
        for (int i = 0; i < NUM_DICE; i++) begin
            cur_die_s = (idx_r == IDX_W'(i)) ? dice[4*i +: 4] : cur_die_s;
        end
    end

    // Roll sequencer, accumulator, classification and point bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            acc_r        <= {SUM_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            dice         <= {(NUM_DICE*4){1'b0}};
            sum          <= {SUM_W{1'b0}};
            done         <= 1'b0;
            busy         <= 1'b0;
            roll_dropped <= 1'b0;
            point        <= {SUM_W{1'b0}};
            point_valid  <= 1'b0;
            seven_out    <= 1'b0;
            natural      <= 1'b0;
            craps        <= 1'b0;
            eq           <= 1'b0;
            roll_count   <= {ROLL_CNT_W{1'b0}};
        end else begin
            done         <= 1'b0;
            // Anything other than IDLE (including EVAL) counts as busy for roll requests.
            roll_dropped <= roll && (state_r != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (roll) begin
                        dice    <= die_s;
                        acc_r   <= {SUM_W{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                        busy    <= 1'b1;
                        state_r <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc_r <= acc_r + SUM_W'(cur_die_s);
                    idx_r <= idx_r + IDX_W'(1'b1);
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    sum       <= acc_r;
                    seven_out <= (acc_r == SUM_W'(7));
                    natural   <= (acc_r == SUM_W'(7)) || (acc_r == SUM_W'(11));
                    craps     <= (acc_r == SUM_W'(2)) || (acc_r == SUM_W'(3)) ||
                                 (acc_r == SUM_W'(12));
                    eq        <= point_valid && (acc_r == point);
                    if (roll_count != {ROLL_CNT_W{1'b1}}) begin
                        roll_count <= roll_count + ROLL_CNT_W'(1'b1);
                    end
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
            // Clear has priority; set only lands while idle (never in the same cycle as EVAL).
            if (clear_point) begin
                point_valid <= 1'b0;
            end else if (set_point && (state_r == ST_IDLE)) begin
                point       <= sum;
                point_valid <= 1'b1;
                roll_count  <= {ROLL_CNT_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_craps_datapath_n.sv
module tb_craps_datapath_n;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic roll = 1'b0;
    logic set_point = 1'b0;
    logic clear_point = 1'b0;

    always #5 clock = ~clock;

    // instance A: defaults (2 dice, 6 sides); instance B: 3 dice, 4 sides, 2-bit counter
    logic [7:0]  dice_a, sum_a, point_a, rc_a;
    logic [11:0] dice_b;
    logic [7:0]  sum_b, point_b;
    logic [1:0]  rc_b;
    logic done_a, busy_a, drop_a, pv_a, so_a, nat_a, cr_a, eq_a;
    logic done_b, busy_b, drop_b, pv_b, so_b, nat_b, cr_b, eq_b;

    craps_datapath_n u_dut_a (
        .clock(clock), .reset(reset), .roll(roll), .set_point(set_point),
        .clear_point(clear_point), .dice(dice_a), .sum(sum_a), .done(done_a),
        .busy(busy_a), .roll_dropped(drop_a), .point(point_a), .point_valid(pv_a),
        .seven_out(so_a), .natural(nat_a), .craps(cr_a), .eq(eq_a), .roll_count(rc_a)
    );

    craps_datapath_n #(.NUM_DICE(3), .SIDES(4), .ROLL_CNT_W(2)) u_dut_b (
        .clock(clock), .reset(reset), .roll(roll), .set_point(set_point),
        .clear_point(clear_point), .dice(dice_b), .sum(sum_b), .done(done_b),
        .busy(busy_b), .roll_dropped(drop_b), .point(point_b), .point_valid(pv_b),
        .seven_out(so_b), .natural(nat_b), .craps(cr_b), .eq(eq_b), .roll_count(rc_b)
    );

    int unsigned o_dice[2], o_sum[2], o_point[2], o_cnt[2], o_flags[2];
    logic o_done[2], o_busy[2], o_drop[2];

    always_comb begin
        o_dice[0] = 32'(dice_a);  o_dice[1] = 32'(dice_b);
        o_sum[0] = 32'(sum_a);    o_sum[1] = 32'(sum_b);
        o_point[0] = 32'(point_a); o_point[1] = 32'(point_b);
        o_cnt[0] = 32'(rc_a);     o_cnt[1] = 32'(rc_b);
        o_flags[0] = 32'({done_a, busy_a, drop_a, pv_a, so_a, nat_a, cr_a, eq_a});
        o_flags[1] = 32'({done_b, busy_b, drop_b, pv_b, so_b, nat_b, cr_b, eq_b});
        o_done[0] = done_a; o_done[1] = done_b;
        o_busy[0] = busy_a; o_busy[1] = busy_b;
        o_drop[0] = drop_a; o_drop[1] = drop_b;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(string nm, int k, int unsigned act, int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s inst=%0d got=%0d want=%0d", nm, k, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nd(int k);       return (k == 0) ? 2 : 3;   endfunction
    function automatic int sides(int k);    return (k == 0) ? 6 : 4;   endfunction
    function automatic int unsigned cmax(int k); return (k == 0) ? 255 : 3; endfunction

    // x^8 + x^6 + x^5 + x^4 + 1, shifted left with feedback into bit 0
    function automatic int unsigned lfsr8_next(int unsigned s);
        int unsigned fb;
        fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
        return ((s << 1) | fb) & 255;
    endfunction

    function automatic int unsigned seed(int i);
        int unsigned s;
        s = (1 + i * 36) % 256;
        return (s == 0) ? 1 : s;
    endfunction

    typedef struct {
        int unsigned dice;
        int unsigned sum;
        int unsigned cnt;
        bit seven, nat, crp, eq;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int unsigned m_lfsr[2][8];
    int unsigned m_pdice[2], m_psum[2], m_sum[2], m_pt[2], m_cnt[2];
    bit m_pv[2];
    int m_busy[2];   // edges left until the done edge; 0 = idle
    int m_drop[2];
    int n_drop[2];
    int n_done[2];

    // What the next posedge does to instance k, given the inputs now driven.
    task automatic model_edge(int k);
        exp_t e;
        bit idle;
        int unsigned d, total, pk;
        if (reset) begin
            for (int i = 0; i < 8; i++) m_lfsr[k][i] = seed(i);
            m_busy[k] = 0; m_sum[k] = 0; m_pt[k] = 0; m_pv[k] = 0; m_cnt[k] = 0;
            if (k == 0) q_a.delete(); else q_b.delete();
            return;
        end
        idle = (m_busy[k] == 0);
        if (!idle) begin
            if (roll) m_drop[k]++;
            if (m_busy[k] == 1) begin
                m_sum[k] = m_psum[k];
                m_cnt[k] = (m_cnt[k] < cmax(k)) ? m_cnt[k] + 1 : m_cnt[k];
                e.dice = m_pdice[k];
                e.sum = m_sum[k];
                e.cnt = m_cnt[k];
                e.seven = (m_sum[k] == 7);
                e.nat = (m_sum[k] == 7) || (m_sum[k] == 11);
                e.crp = (m_sum[k] == 2) || (m_sum[k] == 3) || (m_sum[k] == 12);
                e.eq = m_pv[k] && (m_sum[k] == m_pt[k]);
                if (k == 0) q_a.push_back(e); else q_b.push_back(e);
            end
            m_busy[k]--;
        end
        if (clear_point) begin
            m_pv[k] = 0;
        end else if (set_point && idle) begin
            m_pt[k] = m_sum[k]; m_pv[k] = 1; m_cnt[k] = 0;
        end
        if (idle && roll) begin
            pk = 0; total = 0;
            for (int i = 0; i < nd(k); i++) begin
                d = m_lfsr[k][i] % sides(k) + 1;
                pk |= d << (4 * i);
                total += d;
            end
            m_pdice[k] = pk; m_psum[k] = total; m_busy[k] = nd(k) + 1;
        end
        for (int i = 0; i < nd(k); i++) m_lfsr[k][i] = lfsr8_next(m_lfsr[k][i]);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (o_drop[k] === 1'b1) n_drop[k]++;
            if (o_done[k] === 1'b1) begin
                n_done[k]++;
                if ((k == 0 && q_a.size() == 0) || (k == 1 && q_b.size() == 0)) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_done inst=%0d got=done want=no_done", k);
                end else begin
                    if (k == 0) e = q_a.pop_front(); else e = q_b.pop_front();
                    chk("dice", k, o_dice[k], e.dice);
                    chk("sum", k, o_sum[k], e.sum);
                    chk("flags_7_nat_craps_eq", k, o_flags[k] & 32'hF,
                        {28'd0, e.seven, e.nat, e.crp, e.eq});
                    chk("roll_count", k, o_cnt[k], e.cnt);
                    chk("busy_at_done", k, 32'(o_busy[k]), 0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(bit r, bit s, bit c, bit rst);
        roll = r; set_point = s; clear_point = c; reset = rst;
        model_edge(0);
        model_edge(1);
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic roll_once();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_zero(int k, string nm);
        chk({nm, "_dice"}, k, o_dice[k], 0);
        chk({nm, "_sum"}, k, o_sum[k], 0);
        chk({nm, "_point"}, k, o_point[k], 0);
        chk({nm, "_count"}, k, o_cnt[k], 0);
        chk({nm, "_flags"}, k, o_flags[k], 0);
    endtask

    task automatic find_sum(int unsigned target, output bit found);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            roll_once();
            if (sum_a == 8'(target)) found = 1'b1;
        end
    endtask

    int base_a, base_b;
    bit found;

    initial begin
        @(negedge clock); #1;
        // reset and idle
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_zero(0, "reset"); chk_zero(1, "reset");
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_zero(0, "idle"); chk_zero(1, "idle");

        // latency, busy and dropped second roll
        base_a = n_done[0]; base_b = n_done[1];
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("busy_after_accept", 0, 32'(busy_a), 1);
        chk("busy_after_accept", 1, 32'(busy_b), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("roll_dropped", 0, 32'(drop_a), 1);
        chk("roll_dropped", 1, 32'(drop_b), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("no_early_done", 0, n_done[0], base_a);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("done_latency", 0, n_done[0], base_a + 1);
        chk("no_early_done", 1, n_done[1], base_b);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("done_latency", 1, n_done[1], base_b + 1);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("single_done", 0, n_done[0], base_a + 1);
        chk("single_done", 1, n_done[1], base_b + 1);
        chk("count_after_one", 0, 32'(rc_a), 1);
        chk("count_after_one", 1, 32'(rc_b), 1);

        // point of 8, then roll until 8 again
        find_sum(8, found);
        chk("find_sum8", 0, 32'(found), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("point_set", 0, 32'(point_a), 8);
        chk("point_valid_set", 0, 32'(pv_a), 1);
        chk("count_cleared", 0, 32'(rc_a), 0);
        find_sum(8, found);
        chk("find_sum8_again", 0, 32'(found), 1);
        chk("eq_on_point", 0, 32'({eq_a, so_a}), 2);

        // point of 5, set+clear together, set while busy
        find_sum(5, found);
        chk("find_sum5", 0, 32'(found), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("point_set5", 0, 32'(point_a), 5);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("clear_wins_valid", 0, 32'(pv_a), 0);
        chk("clear_wins_point", 0, 32'(point_a), 5);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("set_while_busy_valid", 0, 32'(pv_a), 0);
        chk("set_while_busy_point", 0, 32'(point_a), 5);
        chk("set_while_busy_model", 0, 32'(point_a), m_pt[0]);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);

        // reset during accumulation aborts the roll
        base_a = n_done[0]; base_b = n_done[1];
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("abort_dice", 0, 32'(dice_a), 0);
        chk("abort_dice", 1, 32'(dice_b), 0);
        chk("abort_busy", 1, 32'(busy_b), 0);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_no_done", 0, n_done[0], base_a);
        chk("abort_no_done", 1, n_done[1], base_b);

        // counter saturation on the 2-bit instance
        repeat (5) roll_once();
        chk("count_saturates", 1, 32'(rc_b), 3);
        chk("count_five", 0, 32'(rc_a), 5);

        // randomized traffic
        repeat (400) step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 11) == 0, $urandom_range(0, 80) == 0);
        repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("queue_drained", 0, q_a.size(), 0);
        chk("queue_drained", 1, q_b.size(), 0);
        chk("drop_count", 0, n_drop[0], m_drop[0]);
        chk("drop_count", 1, n_drop[1], m_drop[1]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
